// File: rtl/stdp_pkg.sv
// Shared defaults and saturating arithmetic for the STDP synapse array.
package stdp_pkg;

  localparam int unsigned DEF_NUM_PRE  = 4;
  localparam int unsigned DEF_TIME_W   = 8;
  localparam int unsigned DEF_WEIGHT_W = 8;
  localparam int unsigned DEF_WINDOW   = 16;
  localparam int unsigned DEF_LTP_STEP = 4;
  localparam int unsigned DEF_LTD_STEP = 2;
  localparam int unsigned DEF_W_INIT   = 128;

  // a + b, clamped to max_v
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] max_v);
    logic [31:0] r;
    if (b > (max_v - a)) r = max_v;
    else                 r = a + b;
    return r;
  endfunction

  // a - b, clamped to 0
  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    if (b > a) r = 32'd0;
    else       r = a - b;
    return r;
  endfunction

endpackage

// File: rtl/stdp_channel.sv
// One synapse: pre-spike timer, weight register, LTP/LTD decision and change flag.
// Define STDP_DECAY_EN to scale the step down with spike distance (STEP >> (dt >> 2)).
module stdp_channel
  import stdp_pkg::*;
#(
  parameter int unsigned TIME_W   = DEF_TIME_W,
  parameter int unsigned WEIGHT_W = DEF_WEIGHT_W,
  parameter int unsigned WINDOW   = DEF_WINDOW,
  parameter int unsigned LTP_STEP = DEF_LTP_STEP,
  parameter int unsigned LTD_STEP = DEF_LTD_STEP,
  parameter int unsigned W_INIT   = DEF_W_INIT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                pre_spike,
  input  logic                post_spike,
  input  logic [TIME_W-1:0]   post_timer,
  output logic [WEIGHT_W-1:0] weight,
  output logic                update_flag
);

  localparam logic [31:0]       W_MAX = 32'((64'd1 << WEIGHT_W) - 64'd1);
  localparam logic [TIME_W-1:0] WIN   = TIME_W'(WINDOW);

  logic [TIME_W-1:0]   pre_timer;
  logic                ltp_c;
  logic                ltd_c;
  logic [31:0]         ltp_step_c;
  logic [31:0]         ltd_step_c;
  logic [WEIGHT_W-1:0] next_w_c;

  // Learning decision uses timer values held before this edge
  always_comb begin
    ltp_c    = en && post_spike && !pre_spike && (pre_timer < WIN);
    ltd_c    = en && pre_spike && !post_spike && (post_timer < WIN);
`ifdef STDP_DECAY_EN
    ltp_step_c = 32'(LTP_STEP) >> (pre_timer >> 2);
    ltd_step_c = 32'(LTD_STEP) >> (post_timer >> 2);
`else
    ltp_step_c = 32'(LTP_STEP);
    ltd_step_c = 32'(LTD_STEP);
`endif
    next_w_c = weight;
    if (ltp_c)      next_w_c = WEIGHT_W'(sat_add(32'(weight), ltp_step_c, W_MAX));
    else if (ltd_c) next_w_c = WEIGHT_W'(sat_sub(32'(weight), ltd_step_c));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_timer   <= '1;
      weight      <= WEIGHT_W'(W_INIT);
      update_flag <= 1'b0;
    end else begin
      update_flag <= 1'b0;
      if (en) begin
        if (pre_spike)              pre_timer <= '0;
        else if (pre_timer != '1)   pre_timer <= pre_timer + TIME_W'(1);
        weight      <= next_w_c;
        update_flag <= (next_w_c != weight);
      end
    end
  end

endmodule

// File: rtl/stdp_array.sv
// Array of STDP synapses sharing one postsynaptic timer, with a registered weight read port.
// Optional macro STDP_DECAY_EN selects distance-scaled steps inside stdp_channel.
module stdp_array
  import stdp_pkg::*;
#(
  parameter int unsigned NUM_PRE  = DEF_NUM_PRE,
  parameter int unsigned TIME_W   = DEF_TIME_W,
  parameter int unsigned WEIGHT_W = DEF_WEIGHT_W,
  parameter int unsigned WINDOW   = DEF_WINDOW,
  parameter int unsigned LTP_STEP = DEF_LTP_STEP,
  parameter int unsigned LTD_STEP = DEF_LTD_STEP,
  parameter int unsigned W_INIT   = DEF_W_INIT,
  localparam int unsigned IDX_W   = (NUM_PRE > 1) ? $clog2(NUM_PRE) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [NUM_PRE-1:0]  pre_spike,
  input  logic                post_spike,
  input  logic                rd_en,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [WEIGHT_W-1:0] rd_weight,
  output logic                rd_valid,
  output logic [NUM_PRE-1:0]  update_flag
);

  logic [TIME_W-1:0]   post_timer;
  logic [WEIGHT_W-1:0] weights [NUM_PRE];
  logic [WEIGHT_W-1:0] rd_data_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      post_timer <= '1;
    end else if (en) begin
      if (post_spike)             post_timer <= '0;
      else if (post_timer != '1)  post_timer <= post_timer + TIME_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_PRE; g++) begin : g_ch
    stdp_channel #(
      .TIME_W  (TIME_W),
      .WEIGHT_W(WEIGHT_W),
      .WINDOW  (WINDOW),
      .LTP_STEP(LTP_STEP),
      .LTD_STEP(LTD_STEP),
      .W_INIT  (W_INIT)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .pre_spike  (pre_spike[g]),
      .post_spike (post_spike),
      .post_timer (post_timer),
      .weight     (weights[g]),
      .update_flag(update_flag[g])
    );
  end

  // Out-of-range indices read as zero
  always_comb begin
    rd_data_c = '0;
    for (int i = 0; i < int'(NUM_PRE); i++) begin
      if (32'(rd_idx) == 32'(i)) rd_data_c = weights[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_weight <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_weight <= rd_data_c;
    end
  end

endmodule

// File: tb/tb_stdp_array.sv
// Directed table-driven bench for stdp_array; row "idle" = cycles of quiet before the next row,
// which equals the timer value (dt) the next row's edge sees.
module tb_stdp_array;

`ifdef STDP_DECAY_EN
  localparam bit DECAY = 1'b1;
`else
  localparam bit DECAY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] pre_spike;
  logic       post_spike;
  logic       rd_en;
  logic [1:0] rd_idx;
  logic [7:0] rd_weight;
  logic       rd_valid;
  logic [3:0] update_flag;

  logic [4:0] pre5;
  logic       rd_en5;
  logic [2:0] rd_idx5;
  logic [7:0] rd_weight5;
  logic       rd_valid5;
  logic [4:0] update_flag5;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stdp_array dut (
    .clk(clk), .rst(rst), .en(en), .pre_spike(pre_spike), .post_spike(post_spike),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_weight(rd_weight), .rd_valid(rd_valid),
    .update_flag(update_flag)
  );

  // Five channels so that index 5 is representable and out of range
  stdp_array #(.NUM_PRE(5)) dut5 (
    .clk(clk), .rst(rst), .en(en), .pre_spike(pre5), .post_spike(1'b0),
    .rd_en(rd_en5), .rd_idx(rd_idx5), .rd_weight(rd_weight5), .rd_valid(rd_valid5),
    .update_flag(update_flag5)
  );

  typedef struct {
    logic [3:0] pre;
    logic       post;
    logic       en;
    logic       rd_en;
    logic [1:0] rd_idx;
    int         idle;
    logic [3:0] flag;
    logic       valid;
    logic [7:0] rdw;
  } vec_t;

  function automatic vec_t v(input logic [3:0] pre, input logic post, input logic e,
                             input logic re, input logic [1:0] idx, input int idle,
                             input logic [3:0] flag, input logic valid, input logic [7:0] rdw);
    vec_t r;
    r.pre = pre; r.post = post; r.en = e; r.rd_en = re; r.rd_idx = idx;
    r.idle = idle; r.flag = flag; r.valid = valid; r.rdw = rdw;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] pre, input logic post, input logic e,
                       input logic re, input logic [1:0] idx);
    pre_spike = pre; post_spike = post; en = e; rd_en = re; rd_idx = idx;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    drive(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0);
    for (int k = 0; k < n; k++) tick();
  endtask

  vec_t tbl[24];
  logic [7:0] a_w0, w1_15;
  logic [3:0] f1_15;
  int w;
  logic [7:0] nw;

  initial begin
    a_w0  = DECAY ? 8'd129 : 8'd132;  // dt=9: step 4>>2=1 with decay
    w1_15 = DECAY ? 8'd128 : 8'd126;  // dt=15: step 2>>3=0 with decay
    f1_15 = DECAY ? 4'b0000 : 4'b0010;

    //            pre     post e  re idx idle flag     vld rdw
    tbl[0]  = v(4'b0000, 1, 1, 0, 0, 20, 4'b0000, 0, 0);      // post only after reset: no learning
    tbl[1]  = v(4'b0001, 0, 1, 0, 0,  9, 4'b0000, 0, 0);
    tbl[2]  = v(4'b0000, 1, 1, 0, 0,  0, 4'b0001, 0, 0);      // LTP ch0
    tbl[3]  = v(4'b0000, 0, 1, 1, 0,  0, 4'b0000, 1, a_w0);
    tbl[4]  = v(4'b0000, 0, 1, 1, 1, 20, 4'b0000, 1, 128);
    tbl[5]  = v(4'b0000, 1, 1, 0, 0,  3, 4'b0000, 0, 0);
    tbl[6]  = v(4'b0100, 0, 1, 0, 0,  0, 4'b0100, 0, 0);      // LTD ch2
    tbl[7]  = v(4'b0000, 0, 1, 1, 2, 20, 4'b0000, 1, 126);
    tbl[8]  = v(4'b0000, 1, 1, 0, 0, 16, 4'b0000, 0, 0);
    tbl[9]  = v(4'b0010, 0, 1, 0, 0,  0, 4'b0000, 0, 0);      // dt=16: outside window
    tbl[10] = v(4'b0000, 0, 1, 1, 1, 20, 4'b0000, 1, 128);
    tbl[11] = v(4'b0000, 1, 1, 0, 0, 15, 4'b0000, 0, 0);
    tbl[12] = v(4'b0010, 0, 1, 0, 0,  0, f1_15,   0, 0);      // dt=15: last cycle inside window
    tbl[13] = v(4'b0000, 0, 1, 1, 1, 20, 4'b0000, 1, w1_15);
    tbl[14] = v(4'b1111, 1, 1, 0, 0,  0, 4'b0000, 0, 0);      // simultaneous spikes
    tbl[15] = v(4'b0000, 0, 1, 1, 0,  2, 4'b0000, 1, a_w0);
    tbl[16] = v(4'b0000, 1, 1, 0, 0,  0, 4'b1111, 0, 0);      // all pre timers reloaded -> LTP all
    tbl[17] = v(4'b0000, 0, 1, 1, 2,  0, 4'b0000, 1, 130);
    tbl[18] = v(4'b0000, 0, 1, 1, 3, 20, 4'b0000, 1, 132);
    tbl[19] = v(4'b0001, 0, 1, 0, 0,  2, 4'b0000, 0, 0);
    tbl[20] = v(4'b0000, 1, 0, 0, 0,  0, 4'b0000, 0, 0);      // en low: frozen
    tbl[21] = v(4'b0000, 0, 0, 1, 0,  0, 4'b0000, 1, a_w0 + 8'd4);
    tbl[22] = v(4'b0000, 1, 1, 0, 0,  0, 4'b0001, 0, 0);      // pre timer held at 2 while frozen
    tbl[23] = v(4'b0000, 0, 1, 1, 0, 20, 4'b0000, 1, a_w0 + 8'd8);

    rst = 1'b1;
    drive(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
    pre5 = '0; rd_en5 = 1'b0; rd_idx5 = 3'd0;
    tick(); tick();
    chk("reset_flag", 32'(update_flag), 0);
    chk("reset_valid", 32'(rd_valid), 0);
    chk("reset_rdw", 32'(rd_weight), 0);
    rst = 1'b0;
    tick();

    // Out-of-range and in-range reads on the 5-channel instance
    rd_en5 = 1'b1; rd_idx5 = 3'd5;
    tick();
    chk("oor_valid", 32'(rd_valid5), 1);
    chk("oor_rdw", 32'(rd_weight5), 0);
    rd_idx5 = 3'd4;
    tick();
    chk("idx4_rdw", 32'(rd_weight5), 128);
    rd_en5 = 1'b0;
    tick();
    chk("rd_valid_pulse", 32'(rd_valid5), 0);
    chk("rdw_hold", 32'(rd_weight5), 128);

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].pre, tbl[i].post, tbl[i].en, tbl[i].rd_en, tbl[i].rd_idx);
      tick();
      chk($sformatf("row%0d_flag", i), 32'(update_flag), 32'(tbl[i].flag));
      chk($sformatf("row%0d_valid", i), 32'(rd_valid), 32'(tbl[i].valid));
      if (tbl[i].valid) chk($sformatf("row%0d_rdw", i), 32'(rd_weight), 32'(tbl[i].rdw));
      idle_cycles(tbl[i].idle);
    end

    // LTP saturation on ch3 (starts at 132)
    w = 132;
    for (int k = 0; k < 40; k++) begin
      drive(4'b1000, 1'b0, 1'b1, 1'b0, 2'd0);
      tick();
      idle_cycles(1);
      drive(4'b0000, 1'b1, 1'b1, 1'b0, 2'd0);
      tick();
      nw = (w + 4 > 255) ? 8'd255 : 8'(w + 4);
      chk($sformatf("ltp_sat%0d_flag", k), 32'(update_flag), {28'd0, (32'(nw) != 32'(w)), 3'b000});
      w = int'(nw);
      idle_cycles(20);
    end
    drive(4'b0000, 1'b0, 1'b1, 1'b1, 2'd3);
    tick();
    chk("ltp_sat_weight", 32'(rd_weight), 255);
    idle_cycles(20);

    // LTD saturation on ch2 (starts at 130)
    w = 130;
    for (int k = 0; k < 68; k++) begin
      drive(4'b0000, 1'b1, 1'b1, 1'b0, 2'd0);
      tick();
      idle_cycles(1);
      drive(4'b0100, 1'b0, 1'b1, 1'b0, 2'd0);
      tick();
      nw = (w < 2) ? 8'd0 : 8'(w - 2);
      chk($sformatf("ltd_sat%0d_flag", k), 32'(update_flag), {28'd0, 1'b0, (32'(nw) != 32'(w)), 2'b00});
      w = int'(nw);
      idle_cycles(20);
    end
    drive(4'b0000, 1'b0, 1'b1, 1'b1, 2'd2);
    tick();
    chk("ltd_sat_weight", 32'(rd_weight), 0);

    // Reset asserted with a read in flight
    drive(4'b0000, 1'b0, 1'b1, 1'b1, 2'd0);
    #3 rst = 1'b1;
    tick();
    chk("rst_read_valid", 32'(rd_valid), 0);
    chk("rst_read_rdw", 32'(rd_weight), 0);
    tick();
    chk("rst_hold_valid", 32'(rd_valid), 0);
    rst = 1'b0;
    drive(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0);
    tick();
    chk("post_rst_valid", 32'(rd_valid), 0);
    for (int i = 0; i < 4; i++) begin
      drive(4'b0000, 1'b0, 1'b1, 1'b1, 2'(i));
      tick();
      chk($sformatf("post_rst_w%0d", i), 32'(rd_weight), 128);
    end
    drive(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
